// File: rtl/seg_ctrl_pkg.sv
// rtl/seg_ctrl_pkg.sv - shared types, constants and saturation helper for the display arbiter
package seg_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        LINGER = 2'd2
    } state_t;

    localparam logic [6:0] SEG_MAX_VAL = 7'd99;
    localparam int         OWNER_W     = 3;

    function automatic logic [6:0] sat_val(input logic [6:0] v);
        return (v > SEG_MAX_VAL) ? SEG_MAX_VAL : v;
    endfunction

endpackage

// File: rtl/disp_pick.sv
// rtl/disp_pick.sv - combinational winner pick, round-robin when DISP_RR_EN is defined, else fixed priority
module disp_pick
    import seg_ctrl_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   pending,
    input  logic [N_REQ-1:0]   exclude,
    input  logic [OWNER_W-1:0] start,
    output logic [OWNER_W-1:0] winner,
    output logic               valid
);

    logic [N_REQ-1:0] elig;
    assign elig = pending & ~exclude;

`ifdef DISP_RR_EN
    // Rotate the eligible mask so bit 0 is the start position, then take the lowest set bit.
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    assign dbl = {elig, elig};
    assign rot = N_REQ'(dbl >> start);

    always_comb begin
        int s;
        winner = '0;
        valid  = 1'b0;
        s      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid && rot[i]) begin
                valid = 1'b1;
                s     = int'(start) + i;
                if (s >= N_REQ) s = s - N_REQ;
                winner = OWNER_W'(s);
            end
        end
    end
`else
    logic unused_start;
    assign unused_start = ^start;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                valid  = 1'b1;
                winner = OWNER_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - shares one 2-digit display among requesters with hold and tenure limits; DISP_RR_EN selects round-robin
module seg_display_arbiter
    import seg_ctrl_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int HOLD_CYC = 5000000,
    parameter int MAX_CYC  = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_val,
    output logic [N_REQ-1:0]     grant,
    output logic [OWNER_W-1:0]   owner,
    output logic [6:0]           disp_value,
    output logic                 disp_blank,
    output logic                 disp_ovf
);

    state_t             state;
    logic [CNT_W-1:0]   tenure;
    logic [CNT_W-1:0]   tenure_inc;
    logic [OWNER_W-1:0] start;
    logic [OWNER_W-1:0] winner;
    logic               pick_valid;
    logic [6:0]         win_val;
    logic [6:0]         own_val;
    logic               own_req;
    logic               hold_done;
    logic               max_done;
    logic               take;
    logic               go_idle;
    logic               go_linger;

    // Excluding the granted requester matters only for preemption; outside SHOW grant is zero.
    disp_pick #(.N_REQ(N_REQ)) u_pick (
        .pending (req),
        .exclude (grant),
        .start   (start),
        .winner  (winner),
        .valid   (pick_valid)
    );

`ifdef DISP_RR_EN
    logic [OWNER_W-1:0] last_owner;
    assign start = (last_owner == OWNER_W'(N_REQ - 1)) ? '0 : last_owner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst)       last_owner <= OWNER_W'(N_REQ - 1);
        else if (take) last_owner <= winner;
    end
`else
    assign start = '0;
`endif

    always_comb begin
        win_val = '0;
        own_val = '0;
        own_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (OWNER_W'(i) == winner) win_val = req_val[7*i +: 7];
            if (OWNER_W'(i) == owner) begin
                own_val = req_val[7*i +: 7];
                own_req = req[i];
            end
        end
    end

    assign tenure_inc = (tenure == '1) ? tenure : tenure + 1'b1;
    assign hold_done  = (tenure >= CNT_W'(HOLD_CYC - 1));
    assign max_done   = (tenure >= CNT_W'(MAX_CYC - 1));

    always_comb begin
        take      = 1'b0;
        go_idle   = 1'b0;
        go_linger = 1'b0;
        case (state)
            IDLE: take = pick_valid;
            SHOW: begin
                if (!own_req) begin
                    if (!hold_done) begin
                        go_linger = 1'b1;
                    end else begin
                        take    = pick_valid;
                        go_idle = !pick_valid;
                    end
                end else if (max_done && pick_valid) begin
                    take = 1'b1;
                end
            end
            LINGER: begin
                if (hold_done) begin
                    take    = pick_valid;
                    go_idle = !pick_valid;
                end
            end
            default: go_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            disp_value <= '0;
            disp_blank <= 1'b1;
            disp_ovf   <= 1'b0;
            tenure     <= '0;
        end else if (take) begin
            state      <= SHOW;
            grant      <= N_REQ'(1) << winner;
            owner      <= winner;
            disp_value <= sat_val(win_val);
            disp_ovf   <= (win_val > SEG_MAX_VAL);
            disp_blank <= 1'b0;
            tenure     <= '0;
        end else if (go_idle) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            disp_value <= '0;
            disp_blank <= 1'b1;
            disp_ovf   <= 1'b0;
            tenure     <= '0;
        end else if (go_linger) begin
            state  <= LINGER;
            grant  <= '0;
            tenure <= tenure_inc;
        end else if (state == SHOW) begin
            disp_value <= sat_val(own_val);
            disp_ovf   <= (own_val > SEG_MAX_VAL);
            tenure     <= tenure_inc;
        end else if (state == LINGER) begin
            tenure <= tenure_inc;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - directed and randomized checks of seg_display_arbiter against a cycle model
module tb_seg_display_arbiter;

    localparam int N     = 4;
    localparam int HOLD  = 4;
    localparam int MAXC  = 10;
    localparam int CW    = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [6:0]   val [4];
    logic [27:0]  req_val;
    logic [3:0]   grant;
    logic [2:0]   owner;
    logic [6:0]   disp_value;
    logic         disp_blank;
    logic         disp_ovf;

    assign req_val = {val[3], val[2], val[1], val[0]};

    seg_display_arbiter #(.N_REQ(N), .HOLD_CYC(HOLD), .MAX_CYC(MAXC), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_val    (req_val),
        .grant      (grant),
        .owner      (owner),
        .disp_value (disp_value),
        .disp_blank (disp_blank),
        .disp_ovf   (disp_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference view: who owns the display (-1 = nobody), how long, and whether the owner has let go.
    int m_own, m_age, m_last, m_val;
    bit m_ling, m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_own = -1; m_age = 0; m_ling = 0; m_val = 0; m_ovf = 0; m_last = N - 1;
    endfunction

    function automatic int pick(input logic [3:0] r, input int excl);
        int idx;
        for (int k = 0; k < N; k++) begin
`ifdef DISP_RR_EN
            idx = (m_last + 1 + k) % N;
`else
            idx = k;
`endif
            if (r[idx[1:0]] && idx != excl) return idx;
        end
        return -1;
    endfunction

    function automatic void m_take(input int w);
        m_own = w; m_ling = 0; m_age = 0; m_last = w;
        m_val = (int'(val[w[1:0]]) > 99) ? 99 : int'(val[w[1:0]]);
        m_ovf = (val[w[1:0]] > 7'd99);
    endfunction

    function automatic void m_rearb(input logic [3:0] r);
        int w;
        w = pick(r, -1);
        if (w >= 0) m_take(w);
        else begin
            m_own = -1; m_ling = 0; m_age = 0; m_val = 0; m_ovf = 0;
        end
    endfunction

    function automatic int age_up(input int a);
        return (a < (1 << CW) - 1) ? a + 1 : a;
    endfunction

    function automatic void model_update(input logic [3:0] r, input logic rs);
        int w;
        if (rs) begin
            m_reset();
        end else if (m_own < 0) begin
            w = pick(r, -1);
            if (w >= 0) m_take(w);
        end else if (m_ling) begin
            if (m_age >= HOLD - 1) m_rearb(r);
            else m_age = age_up(m_age);
        end else if (!r[m_own[1:0]]) begin
            if (m_age < HOLD - 1) begin
                m_ling = 1;
                m_age  = age_up(m_age);
            end else m_rearb(r);
        end else begin
            w = pick(r, m_own);
            if (m_age >= MAXC - 1 && w >= 0) m_take(w);
            else begin
                m_val = (int'(val[m_own[1:0]]) > 99) ? 99 : int'(val[m_own[1:0]]);
                m_ovf = (val[m_own[1:0]] > 7'd99);
                m_age = age_up(m_age);
            end
        end
    endfunction

    task automatic step(input logic [3:0] r, input logic rs);
        logic [3:0] eg;
        req = r;
        rst = rs;
        @(posedge clk);
        model_update(r, rs);
        #1;
        eg = (m_own >= 0 && !m_ling) ? (4'b0001 << m_own) : 4'b0000;
        check("grant", 32'(grant), 32'(eg));
        check("owner", 32'(owner), 32'((m_own < 0) ? 0 : m_own));
        check("value", 32'(disp_value), 32'(m_val));
        check("blank", 32'(disp_blank), 32'(m_own < 0));
        check("ovf", 32'(disp_ovf), 32'(m_ovf));
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] prev;
        int seq[$];
        int cnt;
        bit seen;

        foreach (val[i]) val[i] = 7'd0;
        m_reset();
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_blank", 32'(disp_blank), 32'd1);
        check("rst_value", 32'(disp_value), 32'd0);

        // single requester, then over-range value
        val[0] = 7'd42;
        step(4'b0001, 1'b0);
        check("t2_grant", 32'(grant), 32'b0001);
        check("t2_value", 32'(disp_value), 32'd42);
        check("t2_blank", 32'(disp_blank), 32'd0);
        val[0] = 7'd120;
        step(4'b0001, 1'b0);
        check("t2_sat", 32'(disp_value), 32'd99);
        check("t2_ovf", 32'(disp_ovf), 32'd1);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b0);

        // reset in the middle of SHOW
        val[1] = 7'd55;
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        check("t1_grant", 32'(grant), 32'd0);
        check("t1_blank", 32'(disp_blank), 32'd1);
        check("t1_value", 32'(disp_value), 32'd0);
        step(4'b0010, 1'b0);
        check("t1_regrant", 32'(grant), 32'b0010);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b0);

        // one-cycle pulse lingers for the hold time
        val[0] = 7'd7;
        step(4'b0001, 1'b0);
        check("t3_value0", 32'(disp_value), 32'd7);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1'b0);
            check("t3_grant", 32'(grant), 32'd0);
            check("t3_hold", 32'(disp_value), 32'd7);
        end
        step(4'b0000, 1'b0);
        check("t3_blank", 32'(disp_blank), 32'd1);

        // preemption after max tenure
        val[2] = 7'd33;
        cnt = 0;
        seen = 0;
        step(4'b0001, 1'b0);
        if (grant == 4'b0001) cnt++;
        step(4'b0001, 1'b0);
        if (grant == 4'b0001) cnt++;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(4'b0101, 1'b0);
            if (grant == 4'b0001) cnt++;
            if (grant == 4'b0100) seen = 1;
        end
        check("t4_switched", 32'(seen), 32'd1);
        check("t4_tenure", 32'(cnt), 32'd10);
        check("t4_noblank", 32'(disp_blank), 32'd0);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b0);

        // rotation among two, then three, constant requesters
        for (int pass = 0; pass < 2; pass++) begin
            r = (pass == 0) ? 4'b0011 : 4'b0111;
            step(4'b0000, 1'b1);
            seq.delete();
            prev = 4'b0000;
            for (int i = 0; i < 36; i++) begin
                step(r, 1'b0);
                if (grant != prev && grant != 4'b0000) seq.push_back(int'(owner));
                prev = grant;
            end
            check("t5_len", 32'(seq.size() >= 4), 32'd1);
            if (seq.size() >= 4) begin
                check("t5_o0", 32'(seq[0]), 32'd0);
                check("t5_o1", 32'(seq[1]), 32'd1);
`ifdef DISP_RR_EN
                check("t5_o2", 32'(seq[2]), (pass == 0) ? 32'd0 : 32'd2);
                check("t5_o3", 32'(seq[3]), (pass == 0) ? 32'd1 : 32'd0);
`else
                check("t5_o2", 32'(seq[2]), 32'd0);
                check("t5_o3", 32'(seq[3]), 32'd1);
`endif
            end
            for (int i = 0; i < 6; i++) step(4'b0000, 1'b0);
        end

        // early drop with another requester waiting
        val[3] = 7'd88;
        step(4'b0001, 1'b0);
        step(4'b1001, 1'b0);
        step(4'b1000, 1'b0);
        check("t6_linger", 32'(grant), 32'd0);
        step(4'b1000, 1'b0);
        check("t6_still", 32'(grant), 32'd0);
        step(4'b1000, 1'b0);
        check("t6_grant", 32'(grant), 32'b1000);
        check("t6_value", 32'(disp_value), 32'd88);
        for (int i = 0; i < 6; i++) step(4'b0000, 1'b0);

        // randomized traffic
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            foreach (val[k]) val[k] = 7'($urandom_range(0, 127));
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            step(r, ($urandom_range(0, 79) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
